// File: rtl/pwm_frame_sequencer.sv
// rtl/pwm_frame_sequencer.sv - frame-boundary sync pulse and slew-limited duty value for pwm_generator
// Targets are buffered one deep and only take effect on a frame boundary (terminal count or external sync).
module pwm_frame_sequencer #(
    parameter int PWM_BITS    = 10,
    parameter int T_LSB_BITS  = 12,
    parameter int STEP_BITS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int T_LSB_RESET = 407,
    parameter int PWM_RESET   = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [T_LSB_BITS-1:0] t_lsb,
    input  logic [STEP_BITS-1:0]  step_size,
    input  logic [PWM_BITS-1:0]   target_value,
    input  logic                  target_valid,
    output logic                  target_ready,
    input  logic                  ext_sync_in,
    input  logic                  ext_sync_en,
    output logic                  sync_signal,
    output logic [PWM_BITS-1:0]   pwm_value,
    output logic                  ramp_busy
);

    localparam int GW = PWM_BITS + 1;
    localparam logic [T_LSB_BITS-1:0] T_ONE    = T_LSB_BITS'(1);
    localparam logic [T_LSB_BITS-1:0] T_RST    = (T_LSB_RESET < 1) ? T_ONE : T_LSB_BITS'(T_LSB_RESET);
    localparam logic [PWM_BITS-1:0]   PWM_RST  = PWM_BITS'(PWM_RESET);
    localparam logic [PWM_BITS-1:0]   SLOT_MAX = {PWM_BITS{1'b1}};

    logic [T_LSB_BITS-1:0]  lsb_cnt_q, lsb_cnt_d;
    logic [T_LSB_BITS-1:0]  t_eff_q, t_eff_d;
    logic [PWM_BITS-1:0]    slot_cnt_q, slot_cnt_d;
    logic [PWM_BITS-1:0]    pwm_q, pwm_d;
    logic [PWM_BITS-1:0]    active_q, active_d;
    logic [PWM_BITS-1:0]    pend_val_q, pend_val_d;
    logic                   pend_q, pend_d;
    logic                   sync_q, sync_d;
    logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
    logic                   ext_prev_q, ext_prev_d;
    logic                   ext_rise_q, ext_rise_d;

    logic                   lsb_last;
    logic                   tc;
    logic                   ext_edge;
    logic                   boundary;
    logic                   accept;
    logic [PWM_BITS-1:0]    new_tgt;
    logic [PWM_BITS-1:0]    stepped;
    logic [GW-1:0]          cur_x, tgt_x, step_x, diff_x, next_x;
    logic                   going_up;

    assign lsb_last = (lsb_cnt_q == t_eff_q - T_ONE);
    assign tc       = lsb_last && (slot_cnt_q == SLOT_MAX);
    assign ext_edge = ext_rise_q && ext_sync_en;
    assign boundary = tc || ext_edge;
    assign accept   = target_valid && !pend_q;
    assign new_tgt  = pend_q ? pend_val_q : active_q;

    // Guard bit keeps the difference and the stepped value free of wrap-around.
    always_comb begin
        cur_x    = {1'b0, pwm_q};
        tgt_x    = {1'b0, new_tgt};
        step_x   = GW'(step_size);
        going_up = (tgt_x >= cur_x);
        diff_x   = going_up ? (tgt_x - cur_x) : (cur_x - tgt_x);
        next_x   = tgt_x;
        if ((step_size != '0) && (diff_x > step_x)) begin
            next_x = going_up ? (cur_x + step_x) : (cur_x - step_x);
        end
        stepped = next_x[PWM_BITS-1:0];
    end

    always_comb begin
        lsb_cnt_d  = lsb_cnt_q;
        slot_cnt_d = slot_cnt_q;
        t_eff_d    = t_eff_q;
        pwm_d      = pwm_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        sync_d     = boundary;
        ext_sync_d = {ext_sync_q[SYNC_STAGES-2:0], ext_sync_in};
        ext_prev_d = ext_sync_q[SYNC_STAGES-1];
        ext_rise_d = ext_sync_q[SYNC_STAGES-1] && !ext_prev_q;

        if (boundary) begin
            lsb_cnt_d  = '0;
            slot_cnt_d = '0;
            t_eff_d    = (t_lsb == '0) ? T_ONE : t_lsb;
            active_d   = new_tgt;
            pwm_d      = stepped;
            pend_d     = 1'b0;
        end else if (lsb_last) begin
            lsb_cnt_d  = '0;
            slot_cnt_d = slot_cnt_q + PWM_BITS'(1);
        end else begin
            lsb_cnt_d  = lsb_cnt_q + T_ONE;
        end

        // Accept is only possible while empty, so it never collides with the boundary clear.
        if (accept) begin
            pend_d     = 1'b1;
            pend_val_d = target_value;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lsb_cnt_q  <= '0;
            slot_cnt_q <= '0;
            t_eff_q    <= T_RST;
            pwm_q      <= PWM_RST;
            active_q   <= PWM_RST;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            sync_q     <= 1'b0;
            ext_sync_q <= '0;
            ext_prev_q <= 1'b0;
            ext_rise_q <= 1'b0;
        end else begin
            lsb_cnt_q  <= lsb_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            t_eff_q    <= t_eff_d;
            pwm_q      <= pwm_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            sync_q     <= sync_d;
            ext_sync_q <= ext_sync_d;
            ext_prev_q <= ext_prev_d;
            ext_rise_q <= ext_rise_d;
        end
    end

    assign sync_signal  = sync_q;
    assign pwm_value    = pwm_q;
    assign target_ready = !pend_q;
    assign ramp_busy    = (pwm_q != active_q);

endmodule

// File: doc/pwm_frame_sequencer.md
Name: pwm_frame_sequencer

Overview:
Upstream stage of pwm_generator. Produces the frame-rate sync_signal pulse and a slew-limited pwm_value for the generator, whose PWM frame is t_lsb × 2^PWM_BITS clk cycles. New brightness targets arrive over a valid/ready handshake and are applied only at frame boundaries, so the generator never sees a value change mid-frame. An optional external sync input re-phases the frame.

Parameters:
PWM_BITS, 10, width of pwm_value; slots per frame = 2^PWM_BITS
T_LSB_BITS, 12, width of t_lsb
STEP_BITS, 4, width of step_size
SYNC_STAGES, 2, synchroniser depth for ext_sync_in (min 2)
T_LSB_RESET, 407, frame LSB period used from reset until the first frame boundary
PWM_RESET, 512, reset value of pwm_value and the active target

Ports:
clk  in  1  clock (100 MHz)
reset  in  1  asynchronous, active-low reset
t_lsb  in  T_LSB_BITS  clk cycles per PWM LSB slot; sampled at each frame boundary
step_size  in  STEP_BITS  max pwm_value change per frame; 0 = jump directly; sampled at boundary
target_value  in  PWM_BITS  requested duty value
target_valid  in  1  target_value valid
target_ready  out  1  one-entry target buffer empty
ext_sync_in  in  1  asynchronous external frame sync
ext_sync_en  in  1  enables ext_sync_in re-phasing
sync_signal  out  1  one-cycle frame-boundary pulse to pwm_generator
pwm_value  out  PWM_BITS  duty value to pwm_generator
ramp_busy  out  1  pwm_value != active target

Behaviour:
- Reset (reset=0, async): lsb_cnt=0, slot_cnt=0, t_eff=T_LSB_RESET, sync_signal=0, pwm_value=PWM_RESET, active_target=PWM_RESET, pending buffer empty (target_ready=1), ramp_busy=0, synchroniser flops=0. Asserting reset mid-ramp discards any pending target.
- Counters: lsb_cnt counts 0..t_eff-1. On wrap, slot_cnt increments over 0..2^PWM_BITS-1. t_eff = max(t_lsb,1), so t_lsb=0 gives a 1024-cycle frame.
- Terminal count (TC) is lsb_cnt==t_eff-1 && slot_cnt==max. Boundary event B = TC | ext_edge.
- On the clk edge where B is true:
  - both counters load 0;
  - sync_signal<=1 for exactly one cycle;
  - t_eff reloads from t_lsb;
  - if pending: active_target<=pending value and pending clears;
  - pwm_value steps toward the new active_target.
- pwm_value and sync_signal change on the same edge; no other edge changes pwm_value.
- Step rule: d = |target − pwm_value|. If step_size==0 or d ≤ step_size, pwm_value=target; otherwise pwm_value ± step_size. Use unsigned arithmetic with one guard bit; no wrap-around past 0 or 2^PWM_BITS−1.
- ramp_busy = (pwm_value != active_target). It is combinational from registers.
- Handshake:
  - target_ready = !pending.
  - valid&&ready on an edge stores target_value and sets pending.
  - An accept on a boundary edge stores the value; it applies at the next boundary.
  - valid while ready=0 holds off with no loss; the source must keep the value stable.
- External sync:
  - ext_sync_in passes through SYNC_STAGES flops, then a rising-edge detector.
  - ext_edge is true only when ext_sync_en=1.
  - If ext_sync_in is first sampled high at edge k, the boundary occurs at edge k+SYNC_STAGES+1.
  - Edges with ext_sync_en=0 are ignored, but the synchroniser keeps running.
  - ext_edge coinciding with TC gives a single boundary: one pulse, one step.

Test Plan:
1. T_LSB_RESET=3, t_lsb=3, release reset -> first sync_signal after 3072 cycles, period 3072, pulse width 1; pwm_value=512, ramp_busy=0.
2. Send target 520 with step_size=4 -> target_ready drops for one frame; pwm_value reads 516 then 520 at successive pulses; ramp_busy clears with the second pulse; no change between pulses.
3. step_size=0, target 0 -> pwm_value=0 at the next pulse. Then target 1023 with step 15 -> +15 per frame, ending exactly at 1023 with no overflow.
4. Two targets back-to-back (600, 100) -> second held (ready=0) until the boundary; 600 is applied first, then 100 is accepted and applied one frame later.
5. ext_sync_en=1, ext_sync_in rises mid-frame (slot 100) -> pulse SYNC_STAGES+1 edges later, counters restart, next natural pulse 3072 cycles after. Same edge with ext_sync_en=0 -> no effect.
6. t_lsb=0 -> frame becomes 1024 cycles after the next boundary. Assert reset mid-ramp with a pending target -> pwm_value=512, ready=1, sync_signal=0 immediately.
